// File: rtl/svi_iso_feedthru_pipe.sv
// Multi-channel retiming feedthrough between power domains with an isolation handshake.
// In-flight data is drained before iso_ack is granted, and outputs are clamped while isolated.
module svi_iso_feedthru_pipe #(
   parameter int               N_CH       = 2,
   parameter int               WIDTH      = 4,
   parameter int               DEPTH      = 2,
   parameter logic [WIDTH-1:0] CLAMP_VAL  = '0,
   parameter int               SETTLE_CYC = 4
) (
   input  logic                    ck,
   input  logic                    arst,
   input  logic [N_CH-1:0]         src_valid,
   input  logic [N_CH*WIDTH-1:0]   src_data,
   input  logic                    iso_req,
   output logic                    iso_ack,
   output logic [N_CH-1:0]         dst_valid,
   output logic [N_CH*WIDTH-1:0]   dst_data,
   output logic                    busy,
   output logic                    iso_viol
);

   localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ISO   = 2'd2,
      WAKE  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic                   iso_ack_q;
   logic                   viol_q;

   logic [N_CH-1:0]        vld_q [DEPTH];
   logic [N_CH*WIDTH-1:0]  dat_q [DEPTH];

   logic                   accept;
   logic                   any_vld;
   logic                   pass;

   assign accept = (state_q == RUN);
   assign pass   = (state_q == RUN) || (state_q == DRAIN);

   // Data is captured every cycle regardless of valid; only the valid bits are gated.
   always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
         for (int k = 0; k < DEPTH; k++) begin
            vld_q[k] <= '0;
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= src_valid & {N_CH{accept}};
         dat_q[0] <= src_data;
         for (int k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
         end
      end
   end

   always_comb begin
      any_vld = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         any_vld = any_vld | (|vld_q[k]);
      end
   end

   always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
         state_q   <= WAKE;
         cnt_q     <= '0;
         iso_ack_q <= 1'b1;
         viol_q    <= 1'b0;
      end else begin
         if ((|src_valid) && (state_q != RUN)) begin
            viol_q <= 1'b1;
         end
         case (state_q)
            RUN: begin
               if (iso_req) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Drain completes even if iso_req drops meanwhile.
               if (!any_vld) begin
                  state_q   <= ISO;
                  iso_ack_q <= 1'b1;
               end
            end
            ISO: begin
               if (!iso_req) begin
                  state_q <= WAKE;
                  cnt_q   <= '0;
               end
            end
            WAKE: begin
               if (iso_req) begin
                  state_q <= ISO;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(SETTLE_CYC)) begin
                  state_q   <= RUN;
                  iso_ack_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= WAKE;
               cnt_q     <= '0;
               iso_ack_q <= 1'b1;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_out
         assign dst_valid[gi]                 = pass & vld_q[DEPTH-1][gi];
         assign dst_data[gi*WIDTH +: WIDTH]   = pass ? dat_q[DEPTH-1][gi*WIDTH +: WIDTH] : CLAMP_VAL;
      end
   endgenerate

   assign iso_ack  = iso_ack_q;
   assign busy     = any_vld;
   assign iso_viol = viol_q;

endmodule

// File: tb/tb_svi_iso_feedthru_pipe.sv
// Randomised scoreboard bench for svi_iso_feedthru_pipe: a timeline model predicts
// per-channel deliveries and the isolation handshake, a monitor checks at negedge.
module tb_svi_iso_feedthru_pipe;

   localparam int               N_CH       = 2;
   localparam int               WIDTH      = 4;
   localparam int               DEPTH      = 2;
   localparam logic [WIDTH-1:0] CLAMP_VAL  = '0;
   localparam int               SETTLE_CYC = 4;

   localparam int M_RUN = 0, M_DRAIN = 1, M_ISO = 2, M_WAKE = 3;

   logic                  ck = 1'b0;
   logic                  arst = 1'b0;
   logic [N_CH-1:0]       src_valid = '0;
   logic [N_CH*WIDTH-1:0] src_data = '0;
   logic                  iso_req = 1'b0;
   logic                  iso_ack;
   logic [N_CH-1:0]       dst_valid;
   logic [N_CH*WIDTH-1:0] dst_data;
   logic                  busy;
   logic                  iso_viol;

   svi_iso_feedthru_pipe #(
      .N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH),
      .CLAMP_VAL(CLAMP_VAL), .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .ck(ck), .arst(arst), .src_valid(src_valid), .src_data(src_data),
      .iso_req(iso_req), .iso_ack(iso_ack), .dst_valid(dst_valid),
      .dst_data(dst_data), .busy(busy), .iso_viol(iso_viol)
   );

   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a timeline of accepted words and a mode derived from iso_req history.
   typedef struct {
      int data;
      int due;
   } exp_t;

   exp_t exp_q [N_CH][$];
   int   cyc      = 0;
   int   last_acc = -100;
   int   m_mode   = M_WAKE;
   int   m_wcnt   = 0;
   bit   m_viol   = 1'b0;

   function automatic bit in_flight(input int at_cyc);
      return (at_cyc - last_acc) < DEPTH;
   endfunction

   always @(posedge ck or negedge arst) begin
      if (!arst) begin
         for (int c = 0; c < N_CH; c++) exp_q[c].delete();
         last_acc = -100;
         m_mode   = M_WAKE;
         m_wcnt   = 0;
         m_viol   = 1'b0;
      end else begin
         bit was_busy;
         cyc++;
         was_busy = in_flight(cyc - 1);
         if (m_mode != M_RUN && (|src_valid)) m_viol = 1'b1;
         if (m_mode == M_RUN) begin
            for (int c = 0; c < N_CH; c++) begin
               if (src_valid[c]) begin
                  exp_q[c].push_back('{data: int'(src_data[c*WIDTH +: WIDTH]), due: cyc + DEPTH - 1});
                  last_acc = cyc;
               end
            end
            if (iso_req) m_mode = M_DRAIN;
         end else if (m_mode == M_DRAIN) begin
            if (!was_busy) m_mode = M_ISO;
         end else if (m_mode == M_ISO) begin
            if (!iso_req) begin
               m_mode = M_WAKE;
               m_wcnt = 0;
            end
         end else begin
            if (iso_req) begin
               m_mode = M_ISO;
               m_wcnt = 0;
            end else if (m_wcnt == SETTLE_CYC) begin
               m_mode = M_RUN;
            end else begin
               m_wcnt++;
            end
         end
      end
   end

   // Monitor: compares every output on the falling edge.
   initial begin
      @(posedge ck);
      forever begin
         @(negedge ck);
         if (!arst) begin
            chk("rst_iso_ack", int'(iso_ack), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_dst_valid", int'(dst_valid), 0);
            chk("rst_iso_viol", int'(iso_viol), 0);
            chk("rst_dst_data", int'(dst_data), int'({N_CH{CLAMP_VAL}}));
         end else begin
            bit clamped;
            clamped = (m_mode == M_ISO) || (m_mode == M_WAKE);
            chk("iso_ack", int'(iso_ack), int'(clamped));
            chk("busy", int'(busy), int'(in_flight(cyc)));
            chk("iso_viol", int'(iso_viol), int'(m_viol));
            if (clamped) begin
               chk("clamp_valid", int'(dst_valid), 0);
               chk("clamp_data", int'(dst_data), int'({N_CH{CLAMP_VAL}}));
            end else begin
               for (int c = 0; c < N_CH; c++) begin
                  if (dst_valid[c]) begin
                     if (exp_q[c].size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                     end else begin
                        exp_t e;
                        e = exp_q[c].pop_front();
                        chk("dst_data", int'(dst_data[c*WIDTH +: WIDTH]), e.data);
                        chk("latency_cycle", cyc, e.due);
                     end
                  end else if (exp_q[c].size() > 0 && exp_q[c][0].due <= cyc) begin
                     void'(exp_q[c].pop_front());
                     chk("missing_valid", 0, 1);
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic wait_mode(input int m, input int lim);
      int n;
      n = 0;
      while (m_mode != m && n < lim) begin
         step();
         n++;
      end
      if (m_mode != m) chk("wait_mode_timeout", m_mode, m);
   endtask

   task automatic drive(input logic [N_CH-1:0] v, input logic [N_CH*WIDTH-1:0] d);
      src_valid = v;
      src_data  = d;
   endtask

   initial begin
      int n;
      repeat (3) step();
      arst = 1'b1;

      // Power-up wake window, then free-running random traffic.
      wait_mode(M_RUN, 20);
      for (int i = 0; i < 200; i++) begin
         drive(N_CH'($urandom), (N_CH*WIDTH)'($urandom));
         step();
      end

      // Single word on channel 0, channel 1 idle.
      drive(2'b01, 8'h0A);
      step();
      drive(2'b00, 8'h00);
      repeat (4) step();

      // Burst on channel 1 with isolation requested alongside the last word.
      drive(2'b10, 8'h10);
      step();
      drive(2'b10, 8'h20);
      step();
      drive(2'b10, 8'h30);
      iso_req = 1'b1;
      step();
      drive(2'b00, 8'h00);
      wait_mode(M_ISO, 20);
      step();
      chk("viol_after_drain", int'(iso_viol), 0);

      // Source traffic while isolated: clamped and flagged.
      drive(2'b11, 8'hFF);
      step();
      drive(2'b00, 8'h00);
      step();
      chk("viol_sticky", int'(iso_viol), 1);

      // Re-isolate mid-wake, then a full wake window.
      iso_req = 1'b0;
      step();
      n = 0;
      while (!(m_mode == M_WAKE && m_wcnt == 2) && n < 20) begin
         step();
         n++;
      end
      iso_req = 1'b1;
      step();
      chk("rewake_iso_ack", int'(iso_ack), 1);
      iso_req = 1'b0;
      n = 0;
      while (n < 20) begin
         step();
         if (!iso_ack) break;
         n++;
      end
      chk("wake_len", n, SETTLE_CYC + 1);

      // Random traffic with random isolation toggles.
      for (int i = 0; i < 600; i++) begin
         drive(N_CH'($urandom), (N_CH*WIDTH)'($urandom));
         if ($urandom_range(0, 15) == 0) iso_req = ~iso_req;
         step();
      end
      drive(2'b00, 8'h00);
      iso_req = 1'b0;
      wait_mode(M_RUN, 40);

      // Asynchronous reset while draining.
      drive(2'b11, 8'h5C);
      step();
      drive(2'b00, 8'h00);
      iso_req = 1'b1;
      step();
      chk("pre_rst_busy", int'(busy), 1);
      #1;
      arst = 1'b0;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_dst_valid", int'(dst_valid), 0);
      chk("async_iso_ack", int'(iso_ack), 1);
      iso_req = 1'b0;
      repeat (2) step();
      arst = 1'b1;

      wait_mode(M_RUN, 20);
      for (int i = 0; i < 50; i++) begin
         drive(N_CH'($urandom), (N_CH*WIDTH)'($urandom));
         step();
      end
      drive(2'b00, 8'h00);
      repeat (DEPTH + 3) step();
      for (int c = 0; c < N_CH; c++) chk("queue_empty", exp_q[c].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
